// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor
// Bit-serial unsigned subtractor: d = a - b - bin, one bit per clock, LSB first.
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             bout_q, bout_d;

    logic             ai, bi, di, br_next;
    logic [WIDTH-1:0] res_shifted;

    assign ai      = a_sh_q[0];
    assign bi      = b_sh_q[0];
    assign di      = ai ^ bi ^ br_q;
    assign br_next = (~ai & bi) | (~(ai ^ bi) & br_q);

    // New difference bit enters at the MSB so the word is aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_single
            assign res_shifted = di;
        end else begin : g_multi
            assign res_shifted = {di, res_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_d       = res_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        br_d        = br_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        bout_d      = bout_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    a_sh_d     = a;
                    b_sh_d     = b;
                    br_d       = bin;
                    cnt_d      = '0;
                    res_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_shifted;
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    d_d         = res_shifted;
                    bout_d      = br_next;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_q       <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            br_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            bout_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_q       <= res_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            br_q        <= br_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            bout_q      <= bout_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign bout      = bout_q;

endmodule

`default_nettype wire
